// File: rtl/boot_pkg.sv
// ============================================================================
// Package : boot_pkg
// Brief   : Shared state encoding, defaults and helpers for the boot loader.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package boot_pkg;

   // Loader state machine encoding
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

   // Largest image accepted by default (256-byte data memory)
   localparam int MAX_WORDS_DEF = 64;

   // Byte lane (0 = bits [7:0]) that the byte with sequence number cnt fills
   function automatic logic [1:0] lane_sel(input logic [1:0] cnt, input logic big_endian);
      return big_endian ? (2'd3 - cnt) : cnt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/word_packer.sv
// ============================================================================
// Module  : word_packer
// Brief   : Collects four bytes into a 32-bit word in the configured lane order
//           and flags the byte that completes the word.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module word_packer
   import boot_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        full_o
);

   logic [1:0]  cnt_q;
   logic [31:0] word_q;
   logic [1:0]  w_lane;

   assign w_lane = lane_sel(cnt_q, BIG_ENDIAN);

   // Accepting the byte with count 3 completes the word
   assign full_o = accept_i && (cnt_q == 2'd3);
   assign word_o = word_q;

   // Byte counter and word buffer; clear wins over a simultaneous accept
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= 2'd0;
         word_q <= 32'd0;
      end else if (clear_i) begin
         cnt_q  <= 2'd0;
         word_q <= 32'd0;
      end else if (accept_i) begin
         word_q[{w_lane, 3'b000} +: 8] <= byte_i;
         cnt_q                         <= cnt_q + 2'd1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/boot_loader.sv
// ============================================================================
// Module  : boot_loader
// Brief   : Receives an image byte stream, writes it word by word into data
//           memory and then releases the CPU from reset.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module boot_loader
   import boot_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = 32'd0,
   parameter int          MAX_WORDS  = MAX_WORDS_DEF,
   parameter bit          BIG_ENDIAN = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [6:0]  len,
   input  logic [7:0]  byte_in,
   input  logic        byte_valid,
   output logic        byte_ready,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_wr,
   output logic        cpu_reset,
   output logic        done,
   output logic        err
);

   state_e      state_q, state_d;
   logic [6:0]  idx_q, idx_d;
   logic [6:0]  len_q, len_d;
   logic        byte_ready_q;
   logic        mem_wr_q;
   logic [31:0] mem_addr_q;
   logic        cpu_reset_q;
   logic        done_q;
   logic        err_q;

   logic        w_clear;
   logic        w_accept;
   logic        w_full;
   logic [31:0] w_word;
   logic [31:0] w_addr;

   // A byte moves only on a valid/ready handshake; ready is high only in RECV
   assign w_accept = byte_valid && byte_ready_q;

   assign w_addr = BASE_ADDR + {23'd0, idx_q, 2'b00};

   word_packer #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_packer (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (w_clear),
      .accept_i (w_accept),
      .byte_i   (byte_in),
      .word_o   (w_word),
      .full_o   (w_full)
   );

   // Next-state decision; IDLE, DONE and ERR share the same start handling
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      w_clear = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               if (len == 7'd0) begin
                  state_d = ST_DONE;
               end else if (int'(len) > MAX_WORDS) begin
                  state_d = ST_ERR;
               end else begin
                  state_d = ST_RECV;
                  idx_d   = 7'd0;
                  len_d   = len;
                  w_clear = 1'b1;
               end
            end
         end
         ST_RECV: begin
            if (w_full) begin
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            idx_d   = idx_q + 7'd1;
            state_d = ((idx_q + 7'd1) == len_q) ? ST_DONE : ST_RECV;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, counters and outputs, all registered from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= 7'd0;
         len_q        <= 7'd0;
         byte_ready_q <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= 32'd0;
         cpu_reset_q  <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         len_q        <= len_d;
         byte_ready_q <= (state_d == ST_RECV);
         mem_wr_q     <= (state_d == ST_WRITE);
         mem_addr_q   <= (state_d == ST_WRITE) ? w_addr : 32'd0;
         cpu_reset_q  <= (state_d != ST_DONE);
         done_q       <= (state_d == ST_DONE);
         err_q        <= (state_d == ST_ERR);
      end
   end

   assign byte_ready = byte_ready_q;
   assign mem_wr     = mem_wr_q;
   assign mem_addr   = mem_addr_q;
   // The packed word is complete for the whole WRITE cycle; zero it otherwise
   assign mem_wdata  = mem_wr_q ? w_word : 32'd0;
   assign cpu_reset  = cpu_reset_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

`default_nettype wire

// File: tb/tb_boot_loader.sv
// ============================================================================
// Module  : tb_boot_loader
// Brief   : Self-checking bench for boot_loader (big- and little-endian DUTs
//           driven in parallel).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boot_loader;

   logic        clk        = 1'b0;
   logic        reset      = 1'b1;
   logic        start      = 1'b0;
   logic [6:0]  len        = 7'd0;
   logic [7:0]  byte_in    = 8'd0;
   logic        byte_valid = 1'b0;

   logic        byte_ready, mem_wr, cpu_reset, done, err;
   logic [31:0] mem_addr, mem_wdata;
   logic        le_byte_ready, le_mem_wr, le_cpu_reset, le_done, le_err;
   logic [31:0] le_mem_addr, le_mem_wdata;

   boot_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(64), .BIG_ENDIAN(1'b1)) u_be (
      .clk(clk), .reset(reset), .start(start), .len(len), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(byte_ready), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wr(mem_wr), .cpu_reset(cpu_reset),
      .done(done), .err(err)
   );

   boot_loader #(.BASE_ADDR(32'd0), .MAX_WORDS(64), .BIG_ENDIAN(1'b0)) u_le (
      .clk(clk), .reset(reset), .start(start), .len(len), .byte_in(byte_in),
      .byte_valid(byte_valid), .byte_ready(le_byte_ready), .mem_addr(le_mem_addr),
      .mem_wdata(le_mem_wdata), .mem_wr(le_mem_wr), .cpu_reset(le_cpu_reset),
      .done(le_done), .err(le_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_be[$];
   logic [31:0] wr_le[$];
   int          ready_viol = 0;

   // Write log, sampled mid-cycle
   always @(negedge clk) begin
      if (mem_wr === 1'b1) begin
         wr_addr.push_back(mem_addr);
         wr_be.push_back(mem_wdata);
         wr_le.push_back(le_mem_wdata);
         if (byte_ready !== 1'b0) ready_viol++;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_be.delete();
      wr_le.delete();
   endtask

   // Called at a negedge; returns at the negedge after start was sampled
   task automatic do_start(input logic [6:0] l);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called at a negedge; returns at the negedge after the byte was accepted
   task automatic send_byte(input logic [7:0] b);
      int n;
      n          = 0;
      byte_in    = b;
      byte_valid = 1'b1;
      while (byte_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         total++;
         bad++;
         $display("FAIL send_timeout: byte_ready stayed %b waiting to send %h", byte_ready, b);
      end
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cpu_reset"}, {31'd0, cpu_reset}, 32'd1);
      chk({tag, "_done"},      {31'd0, done},      32'd0);
      chk({tag, "_err"},       {31'd0, err},       32'd0);
      chk({tag, "_mem_wr"},    {31'd0, mem_wr},    32'd0);
      chk({tag, "_ready"},     {31'd0, byte_ready}, 32'd0);
      chk({tag, "_addr"},      mem_addr,           32'd0);
      chk({tag, "_wdata"},     mem_wdata,          32'd0);
   endtask

   typedef struct {
      logic [31:0] bytes;    // first byte sent is bits [31:24]
      logic [31:0] exp_be;
      logic [31:0] exp_le;
   } vec_t;

   vec_t vecs[3];

   initial begin
      vecs[0] = '{bytes: 32'h12345678, exp_be: 32'h12345678, exp_le: 32'h78563412};
      vecs[1] = '{bytes: 32'hDEADBEEF, exp_be: 32'hDEADBEEF, exp_le: 32'hEFBEADDE};
      vecs[2] = '{bytes: 32'h00FF0180, exp_be: 32'h00FF0180, exp_le: 32'h8001FF00};

      // Asynchronous reset with no clock edge involved
      #1 reset = 1'b0;
      #1 chk_reset_vals("rst");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("idle_ready",     {31'd0, byte_ready}, 32'd0);

      // Single-word images from the table, both lane orders
      for (int v = 0; v < 3; v++) begin
         logic [31:0] bb;
         bb = vecs[v].bytes;
         clear_log();
         do_start(7'd1);
         chk($sformatf("v%0d_ready", v), {31'd0, byte_ready}, 32'd1);
         for (int k = 0; k < 4; k++) send_byte(bb[31 - 8*k -: 8]);
         chk($sformatf("v%0d_wr", v),       {31'd0, mem_wr},     32'd1);
         chk($sformatf("v%0d_addr", v),     mem_addr,            32'd0);
         chk($sformatf("v%0d_be", v),       mem_wdata,           vecs[v].exp_be);
         chk($sformatf("v%0d_le", v),       le_mem_wdata,        vecs[v].exp_le);
         chk($sformatf("v%0d_wr_ready", v), {31'd0, byte_ready}, 32'd0);
         chk($sformatf("v%0d_early_done", v), {31'd0, done},     32'd0);
         @(negedge clk);
         chk($sformatf("v%0d_done", v),     {31'd0, done},       32'd1);
         chk($sformatf("v%0d_cpu_rel", v),  {31'd0, cpu_reset},  32'd0);
         chk($sformatf("v%0d_wr_off", v),   {31'd0, mem_wr},     32'd0);
         chk($sformatf("v%0d_addr0", v),    mem_addr,            32'd0);
         chk($sformatf("v%0d_data0", v),    mem_wdata,           32'd0);
         chk($sformatf("v%0d_nwr", v),      wr_addr.size(),      32'd1);
      end

      // Zero-length image: released on the next cycle, nothing written
      clear_log();
      do_start(7'd0);
      chk("len0_done",      {31'd0, done},      32'd1);
      chk("len0_cpu_reset", {31'd0, cpu_reset}, 32'd0);
      @(negedge clk);
      chk("len0_nwr", wr_addr.size(), 32'd0);

      // Oversized image rejected, bytes refused, then a retry loads normally
      clear_log();
      do_start(7'd65);
      chk("err_flag",      {31'd0, err},       32'd1);
      chk("err_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      chk("err_done",      {31'd0, done},      32'd0);
      byte_valid = 1'b1;
      byte_in    = 8'hEE;
      repeat (2) @(negedge clk);
      chk("err_ready", {31'd0, byte_ready}, 32'd0);
      byte_valid = 1'b0;
      do_start(7'd2);
      chk("retry_err_clr",   {31'd0, err},       32'd0);
      chk("retry_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      for (int k = 0; k < 8; k++) send_byte(8'hA0 + 8'(k));
      @(negedge clk);
      chk("retry_done", {31'd0, done}, 32'd1);
      chk("retry_nwr",  wr_addr.size(), 32'd2);
      if (wr_addr.size() == 2) begin
         chk("retry_a0", wr_addr[0], 32'd0);
         chk("retry_a1", wr_addr[1], 32'd4);
         chk("retry_d0", wr_be[0],   32'hA0A1A2A3);
         chk("retry_d1", wr_be[1],   32'hA4A5A6A7);
      end

      // Three words with an idle cycle after every byte
      clear_log();
      ready_viol = 0;
      do_start(7'd3);
      for (int w = 0; w < 3; w++) begin
         for (int k = 0; k < 4; k++) begin
            send_byte(8'(16*w + k));
            @(negedge clk);
         end
      end
      chk("gap_done", {31'd0, done}, 32'd1);
      chk("gap_nwr",  wr_addr.size(), 32'd3);
      if (wr_addr.size() == 3) begin
         chk("gap_a0",  wr_addr[0], 32'd0);
         chk("gap_a1",  wr_addr[1], 32'd4);
         chk("gap_a2",  wr_addr[2], 32'd8);
         chk("gap_d0",  wr_be[0],   32'h00010203);
         chk("gap_d1",  wr_be[1],   32'h10111213);
         chk("gap_d2",  wr_be[2],   32'h20212223);
         chk("gap_le2", wr_le[2],   32'h23222120);
      end
      chk("gap_ready_in_write", ready_viol, 32'd0);

      // Reset in the middle of the second word
      clear_log();
      do_start(7'd2);
      for (int k = 0; k < 6; k++) send_byte(8'h50 + 8'(k));
      reset = 1'b0;
      #1 chk_reset_vals("mid");
      byte_valid = 1'b1;
      byte_in    = 8'h77;
      repeat (3) @(negedge clk);
      byte_valid = 1'b0;
      reset      = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_nwr",       wr_addr.size(), 32'd1);
      if (wr_addr.size() == 1) begin
         chk("mid_a0", wr_addr[0], 32'd0);
         chk("mid_d0", wr_be[0],   32'h50515253);
         chk("mid_l0", wr_le[0],   32'h53525150);
      end
      chk("mid_idle_cpu",  {31'd0, cpu_reset}, 32'd1);
      chk("mid_idle_done", {31'd0, done},      32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'd0, byte address of first word written.
REQ-002 Parameter MAX_WORDS, default 64, largest accepted image length in words (256-byte memory).
REQ-003 Parameter BIG_ENDIAN, default 1, first received byte lands in bits [31:24] when 1, in [7:0] when 0.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin loading an image.
REQ-007 len  input  7  image length in words, sampled with start.
REQ-008 byte_in  input  8  incoming image byte.
REQ-009 byte_valid  input  1  byte_in holds a valid byte.
REQ-010 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-011 mem_addr  output  32  byte address to the data memory.
REQ-012 mem_wdata  output  32  assembled word to memory.
REQ-013 mem_wr  output  1  memory write strobe, one cycle per word.
REQ-014 cpu_reset  output  1  active-high hold of the CPU's reset input.
REQ-015 done  output  1  image loaded, CPU released.
REQ-016 err  output  1  rejected length.

Function
REQ-017 The FSM SHALL have states IDLE, RECV, WRITE, DONE, ERR.
REQ-018 IDLE: cpu_reset=1, byte_ready=0; on start with len=0 go DONE; len>MAX_WORDS go ERR; otherwise clear word index and byte counter, go RECV.
REQ-019 RECV: byte_ready=1; a byte is accepted only when byte_valid && byte_ready; byte counter 0..3 selects lane per BIG_ENDIAN.
REQ-020 On accepting the 4th byte, the next state SHALL be WRITE; byte_ready SHALL be 0 in WRITE.
REQ-021 WRITE: mem_wr=1 for exactly one cycle, mem_addr=BASE_ADDR+4*index, mem_wdata=assembled word; then index increments.
REQ-022 After WRITE, go DONE when incremented index equals len, otherwise RECV with byte counter 0.
REQ-023 mem_addr and mem_wdata SHALL be 0 whenever mem_wr=0.
REQ-024 DONE: cpu_reset=0, done=1, byte_ready=0; start re-enters the IDLE decision in the same edge (cpu_reset reasserts next cycle).
REQ-025 ERR: err=1, cpu_reset=1; start retries as in IDLE; bytes are not accepted.
REQ-026 start SHALL be ignored in RECV and WRITE; byte_valid SHALL be ignored outside RECV.
REQ-027 Index SHALL be 7 bits; the last address written is BASE_ADDR+4*(len-1), never wrapping within 64 words.
REQ-028 Worst-case latency from last byte accepted to done=1 SHALL be 2 cycles (WRITE then DONE).

Reset
REQ-029 On reset low, state SHALL become IDLE asynchronously; cpu_reset=1; done, err, mem_wr, byte_ready=0; index, byte counter, word buffer=0.
REQ-030 Reset mid-image SHALL discard the partial word and perform no further memory writes.

Structure
REQ-031 State encoding and MAX_WORDS default SHALL live in a shared package boot_pkg.
REQ-032 Byte-to-word assembly SHALL be one sub-module word_packer (lane select, count, full flag); the FSM stays in boot_loader.

Verification
REQ-033 len=1, bytes 12 34 56 78, BIG_ENDIAN=1 -> one mem_wr, addr 0, data 32'h12345678, done=1 two cycles after last byte.
REQ-034 len=3, byte_valid toggled every other cycle -> writes at 0,4,8, no bytes lost, byte_ready=0 during each WRITE.
REQ-035 len=0 -> no mem_wr, done=1 and cpu_reset=0 the cycle after start.
REQ-036 len=65 -> err=1, cpu_reset=1, no writes; then start with len=2 -> normal load completes.
REQ-037 reset pulsed low after 6 bytes of len=2 -> exactly one write seen (addr 0), outputs at reset values immediately.
REQ-038 BIG_ENDIAN=0, bytes 12 34 56 78 -> mem_wdata 32'h78563412.
